// File: rtl/pll_seq_ctrl_if.sv
// Configuration request bus plus the PLL dynamic-config port (PLLSTB/PLLWE/PLLADDR/PLLDATI/PLLDATO/PLLACK).
// The master side is the sequencer; the slave side is the requester and the PLL.
interface pll_seq_ctrl_if;
  logic       cfg_req;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       cfg_done;
  logic       cfg_err;
  logic       pll_stb;
  logic       pll_we;
  logic [4:0] pll_addr;
  logic [7:0] pll_dati;
  logic [7:0] pll_dato;
  logic       pll_ack;

  modport master (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata, pll_dato, pll_ack,
    output cfg_rdata, cfg_done, cfg_err, pll_stb, pll_we, pll_addr, pll_dati
  );

  modport slave (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata, pll_dato, pll_ack,
    input  cfg_rdata, cfg_done, cfg_err, pll_stb, pll_we, pll_addr, pll_dati
  );
endinterface

// File: rtl/pll_seq_ctrl.sv
// PLL bring-up sequencer: reset hold, lock qualification with timeout/retry, lock-loss
// recovery, and arbitration of single configuration accesses while the PLL is running.
module pll_seq_ctrl #(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic       clk_10M_ref,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       pll_clk_en,
  output logic       pll_ready,
  output logic       lock_fail,
  output logic [7:0] lost_cnt,
  output logic       busy,
  pll_seq_ctrl_if.master bus
);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int WW = $clog2(LOCK_TIMEOUT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0]    HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [SW-1:0] STAB_N    = SW'(LOCK_STABLE);
  localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {HOLD, WAIT_LOCK, RUN, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [1:0]    lock_sync;
  logic          lock_s;
  logic [7:0]    hold_cnt;
  logic [SW-1:0] stab_cnt;
  logic [WW-1:0] wait_cnt;
  logic [AW-1:0] acc_cnt;
  logic          take, rej, fin_ok, fin_to, tmo, loss, run_nxt;

  always_ff @(posedge clk_10M_ref) begin
    if (!rst_n) lock_sync <= 2'b00;
    else        lock_sync <= {lock_sync[0], pll_lock};
  end
  assign lock_s = lock_sync[1];

  always_ff @(posedge clk_10M_ref) begin
    if (!rst_n) state <= HOLD;
    else        state <= state_nxt;
  end

  // Lock loss beats a same-cycle request; an ACCESS completion beats a request that arrives with it.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    rej       = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    tmo       = 1'b0;
    loss      = 1'b0;
    case (state)
      HOLD: begin
        rej = bus.cfg_req;
        if (hold_cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        rej = bus.cfg_req;
        if (stab_cnt == STAB_N) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = HOLD;
          tmo       = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = HOLD;
          loss      = 1'b1;
          rej       = bus.cfg_req;
        end else if (bus.cfg_req) begin
          state_nxt = ACCESS;
          take      = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.pll_ack) begin
          fin_ok    = 1'b1;
          state_nxt = bus.pll_we ? HOLD : RUN;
        end else if (acc_cnt == ACK_LAST) begin
          fin_to    = 1'b1;
          state_nxt = RUN;
        end else begin
          rej = bus.cfg_req;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  // Every counter restarts from zero whenever its state is (re)entered.
  always_ff @(posedge clk_10M_ref) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      stab_cnt <= '0;
      wait_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      hold_cnt <= (state == HOLD && state_nxt == HOLD) ? hold_cnt + 8'd1 : '0;
      wait_cnt <= (state == WAIT_LOCK && state_nxt == WAIT_LOCK) ? wait_cnt + WW'(1) : '0;
      stab_cnt <= (state == WAIT_LOCK && state_nxt == WAIT_LOCK && lock_s) ? stab_cnt + SW'(1) : '0;
      acc_cnt  <= (state == ACCESS && state_nxt == ACCESS) ? acc_cnt + AW'(1) : '0;
    end
  end

  assign run_nxt = (state_nxt == RUN) || (state_nxt == ACCESS);

  // Outputs are flops fed from the next state so the PLL pins never see decode glitches.
  always_ff @(posedge clk_10M_ref) begin
    if (!rst_n) begin
      pll_rst       <= 1'b1;
      pll_clk_en    <= 1'b0;
      pll_ready     <= 1'b0;
      busy          <= 1'b1;
      lock_fail     <= 1'b0;
      lost_cnt      <= '0;
      bus.cfg_rdata <= '0;
      bus.cfg_done  <= 1'b0;
      bus.cfg_err   <= 1'b0;
      bus.pll_stb   <= 1'b0;
      bus.pll_we    <= 1'b0;
      bus.pll_addr  <= '0;
      bus.pll_dati  <= '0;
    end else begin
      pll_rst      <= (state_nxt == HOLD);
      pll_clk_en   <= run_nxt;
      pll_ready    <= run_nxt;
      busy         <= (state_nxt != RUN);
      bus.cfg_done <= rej | fin_ok | fin_to;
      bus.cfg_err  <= rej | fin_to;
      if (tmo) lock_fail <= 1'b1;
      if (loss && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      if (fin_ok && !bus.pll_we) bus.cfg_rdata <= bus.pll_dato;
      // The PLL-side registers double as the captured request for the whole access.
      if (take) begin
        bus.pll_stb  <= 1'b1;
        bus.pll_we   <= bus.cfg_we;
        bus.pll_addr <= bus.cfg_addr;
        bus.pll_dati <= bus.cfg_wdata;
      end else if (state_nxt != ACCESS) begin
        bus.pll_stb  <= 1'b0;
        bus.pll_we   <= 1'b0;
        bus.pll_addr <= '0;
        bus.pll_dati <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Randomized bench for pll_seq_ctrl; expectations come from latency arithmetic and
// simple counters (lost events, sticky fail, last read data).
module tb_pll_seq_ctrl;
  localparam int RST_HOLD     = 16;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int ACK_TIMEOUT  = 15;
  localparam int RDY_NOM      = RST_HOLD + 2 + LOCK_STABLE;

  logic       clk_10M_ref = 1'b0;
  logic       rst_n, pll_lock;
  logic       pll_rst, pll_clk_en, pll_ready, lock_fail, busy;
  logic [7:0] lost_cnt;

  always #50 clk_10M_ref = ~clk_10M_ref;

  pll_seq_ctrl_if bus ();

  pll_seq_ctrl #(
    .RST_HOLD(RST_HOLD), .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_10M_ref(clk_10M_ref), .rst_n(rst_n), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .pll_clk_en(pll_clk_en), .pll_ready(pll_ready),
    .lock_fail(lock_fail), .lost_cnt(lost_cnt), .busy(busy), .bus(bus)
  );

  int         errs = 0, checks = 0;
  int         exp_lost = 0;
  logic       exp_fail = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk_10M_ref);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rst"}, pll_rst, 1);        chk({tag, ".clken"}, pll_clk_en, 0);
    chk({tag, ".ready"}, pll_ready, 0);    chk({tag, ".fail"}, lock_fail, 0);
    chk({tag, ".lost"}, lost_cnt, 0);      chk({tag, ".rdata"}, bus.cfg_rdata, 0);
    chk({tag, ".done"}, bus.cfg_done, 0);  chk({tag, ".err"}, bus.cfg_err, 0);
    chk({tag, ".busy"}, busy, 1);          chk({tag, ".stb"}, bus.pll_stb, 0);
    chk({tag, ".we"}, bus.pll_we, 0);      chk({tag, ".addr"}, bus.pll_addr, 0);
    chk({tag, ".dati"}, bus.pll_dati, 0);
  endtask

  task automatic chk_run(input string tag);
    chk({tag, ".run_rdy"}, pll_ready, 1);  chk({tag, ".run_en"}, pll_clk_en, 1);
    chk({tag, ".run_busy"}, busy, 0);      chk({tag, ".run_rst"}, pll_rst, 0);
    chk({tag, ".run_stb"}, bus.pll_stb, 0); chk({tag, ".run_done"}, bus.cfg_done, 0);
    chk({tag, ".lost"}, lost_cnt, exp_lost);
    chk({tag, ".fail"}, lock_fail, exp_fail);
    chk({tag, ".rdata"}, bus.cfg_rdata, exp_rdata);
  endtask

  // Called on the first HOLD sample with pll_lock already high.
  task automatic relock(input string tag, input bit rej);
    int rst_lo = -1;
    int rdy = -1;
    chk({tag, ".hold0"}, pll_rst, 1);
    chk({tag, ".rdy0"}, pll_ready, 0);
    if (rej) bus.cfg_req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      nx();
      if (rej && k == 1) begin
        bus.cfg_req = 1'b0;
        chk({tag, ".rej_done"}, bus.cfg_done, 1);
        chk({tag, ".rej_err"}, bus.cfg_err, 1);
        chk({tag, ".rej_stb"}, bus.pll_stb, 0);
      end
      if (rej && k == 2) chk({tag, ".rej_pulse"}, bus.cfg_done, 0);
      if (!pll_rst && rst_lo < 0) rst_lo = k;
      if (pll_ready) begin
        rdy = k;
        break;
      end
    end
    chk({tag, ".hold_len"}, rst_lo, RST_HOLD);
    chk({tag, ".rdy_win"}, (rdy >= RDY_NOM - 1 && rdy <= RDY_NOM + 1), 1);
  endtask

  task automatic bump_lost();
    exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
  endtask

  task automatic lose_lock(input string tag, input bit rej, input bit coll);
    int k0 = -1;
    pll_lock = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (coll && k == 3) bus.cfg_req = 1'b1;
      nx();
      if (coll && k == 3) bus.cfg_req = 1'b0;
      if (!pll_ready) begin
        k0 = k;
        break;
      end
    end
    bump_lost();
    chk({tag, ".drop_lat"}, k0, 3);
    chk({tag, ".lost"}, lost_cnt, exp_lost);
    chk({tag, ".clken"}, pll_clk_en, 0);
    if (coll) begin
      chk({tag, ".coll_done"}, bus.cfg_done, 1);
      chk({tag, ".coll_err"}, bus.cfg_err, 1);
      chk({tag, ".coll_stb"}, bus.pll_stb, 0);
    end
    pll_lock = 1'b1;
    relock(tag, rej);
  endtask

  // d = ack on the d-th strobe cycle, 0 = never ack; drop = lose lock during the access.
  task automatic access(input string tag, input bit we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [7:0] dato, input int d, input bit drop);
    bit held = 1'b1;
    int n = 0;
    bus.cfg_req = 1'b1; bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_wdata = wd;
    nx();
    bus.cfg_req = 1'b0;
    bus.cfg_we = 1'($urandom); bus.cfg_addr = 5'($urandom); bus.cfg_wdata = 8'($urandom);
    if (drop) pll_lock = 1'b0;
    while (bus.pll_stb && n < 40) begin
      n++;
      if (!(bus.pll_we == we && bus.pll_addr == addr && bus.pll_dati == wd &&
            pll_ready && busy && !bus.cfg_done)) held = 1'b0;
      if (d > 0 && n == d) begin
        bus.pll_ack = 1'b1;
        bus.pll_dato = dato;
      end
      nx();
      bus.pll_ack = 1'b0;
      bus.pll_dato = 8'($urandom);
    end
    chk({tag, ".held"}, held, 1);
    chk({tag, ".stb_len"}, n, (d > 0) ? d : ACK_TIMEOUT);
    chk({tag, ".done"}, bus.cfg_done, 1);
    chk({tag, ".err"}, bus.cfg_err, (d == 0));
    chk({tag, ".idle_bus"}, {bus.pll_stb, bus.pll_we, bus.pll_addr, bus.pll_dati}, 0);
    if (d > 0 && !we) exp_rdata = dato;
    chk({tag, ".rdata"}, bus.cfg_rdata, exp_rdata);
    if (d > 0 && we) begin
      chk({tag, ".wr_rdy"}, pll_ready, 0);
      pll_lock = 1'b1;
      relock({tag, ".relock"}, 1'b0);
    end else begin
      chk({tag, ".keep_rdy"}, pll_ready, 1);
      nx();
      chk({tag, ".pulse"}, bus.cfg_done, 0);
      if (drop) begin
        bump_lost();
        chk({tag, ".late_drop"}, pll_ready, 0);
        chk({tag, ".late_lost"}, lost_cnt, exp_lost);
        pll_lock = 1'b1;
        relock({tag, ".relock"}, 1'b0);
      end else begin
        chk_run(tag);
      end
    end
  endtask

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  int         kind, kf;
  bit         rdy_seen;
  logic [4:0] a;
  logic [7:0] w, r;

  initial begin
    rst_n = 1'b0; pll_lock = 1'b1;
    bus.cfg_req = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.pll_ack = 1'b0; bus.pll_dato = '0;
    repeat (4) nx();
    chk_reset("por");
    rst_n = 1'b1;
    relock("boot", 1'b0);
    chk_run("boot");

    // Lock never arrives: sticky failure, then retry succeeds once lock appears.
    rst_n = 1'b0; pll_lock = 1'b0;
    repeat (3) nx();
    rst_n = 1'b1;
    kf = -1; rdy_seen = 1'b0;
    for (int k = 1; k <= RST_HOLD + LOCK_TIMEOUT + 50; k++) begin
      nx();
      if (pll_ready) rdy_seen = 1'b1;
      if (lock_fail) begin
        kf = k;
        break;
      end
    end
    chk("tmo.when", kf, RST_HOLD + LOCK_TIMEOUT);
    chk("tmo.hold", pll_rst, 1);
    chk("tmo.no_rdy", rdy_seen, 0);
    exp_fail = 1'b1; exp_lost = 0; exp_rdata = 8'h00;
    pll_lock = 1'b1;
    relock("retry", 1'b0);
    chk_run("retry");

    access("rd05", 1'b0, 5'h05, 8'h00, 8'hA5, 3, 1'b0);
    access("wr02", 1'b1, 5'h02, 8'h3C, 8'h00, 2, 1'b0);
    chk_run("wr02");
    access("noack", 1'b0, 5'h11, 8'h00, 8'h00, 0, 1'b0);
    lose_lock("holdreq", 1'b1, 1'b0);
    lose_lock("coll", 1'b0, 1'b1);
    access("accdrop", 1'b0, 5'h07, 8'h55, 8'h9C, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      a = 5'($urandom); w = 8'($urandom); r = 8'($urandom);
      case (kind)
        0: access("r_rd", 1'b0, a, w, r, $urandom_range(1, ACK_TIMEOUT - 1), 1'b0);
        1: access("r_wr", 1'b1, a, w, r, $urandom_range(1, ACK_TIMEOUT - 1), 1'b0);
        2: access("r_to", 1'($urandom), a, w, r, 0, 1'b0);
        3: lose_lock("r_loss", 1'($urandom), 1'b0);
        4: lose_lock("r_coll", 1'b0, 1'b1);
        default: access("r_drop", 1'b0, a, w, r,
                        ($urandom_range(0, 1) != 0) ? $urandom_range(2, ACK_TIMEOUT - 1) : 0, 1'b1);
      endcase
      chk_run("r_end");
    end

    for (int i = 0; i < 300; i++) lose_lock("sat", 1'b0, 1'b0);
    chk("sat.final", lost_cnt, 255);
    chk_run("sat");

    // Reset in the middle of an access.
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 5'h09; bus.cfg_wdata = 8'h00;
    nx();
    bus.cfg_req = 1'b0;
    chk("midacc.stb", bus.pll_stb, 1);
    rst_n = 1'b0;
    nx();
    chk_reset("midacc");
    nx();
    chk("midacc.nodone", bus.cfg_done, 0);
    rst_n = 1'b1;
    exp_lost = 0; exp_fail = 1'b0; exp_rdata = 8'h00;
    relock("postrst", 1'b0);
    chk_run("postrst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
